// File: rtl/split_3layers.sv
// Channel deinterleaver: regroups an interleaved ch1/ch2/ch3 word stream into
// three aligned per-channel outputs, counting pixels per D x D frame.
module split_3layers #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  sof_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic [DATA_WIDTH-1:0] pxl_out_3,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic                  frame_done,
    output logic                  err
);

    localparam int PIX_W = (D * D > 1) ? $clog2(D * D) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(D * D - 1);

    logic [1:0]            ch_cnt;
    logic [PIX_W-1:0]      pix_cnt;
    logic [DATA_WIDTH-1:0] hold1;
    logic [DATA_WIDTH-1:0] hold2;
    logic                  vld_p0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_cnt     <= 2'd0;
            pix_cnt    <= '0;
            hold1      <= '0;
            hold2      <= '0;
            pxl_out_1  <= '0;
            pxl_out_2  <= '0;
            pxl_out_3  <= '0;
            vld_p0     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            vld_p0     <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                // A start-of-frame beat always restarts the triple, even if one is pending.
                if (sof_in) begin
                    if (ch_cnt != 2'd0 || pix_cnt != '0)
                        err <= 1'b1;
                    hold1   <= pxl_in;
                    ch_cnt  <= 2'd1;
                    pix_cnt <= '0;
                end else begin
                    case (ch_cnt)
                        2'd0: begin
                            hold1  <= pxl_in;
                            ch_cnt <= 2'd1;
                        end
                        2'd1: begin
                            hold2  <= pxl_in;
                            ch_cnt <= 2'd2;
                        end
                        default: begin
                            pxl_out_1 <= hold1;
                            pxl_out_2 <= hold2;
                            pxl_out_3 <= pxl_in;
                            vld_p0    <= 1'b1;
                            ch_cnt    <= 2'd0;
                            if (pix_cnt == LAST_PIX) begin
                                pix_cnt    <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // One registered valid fans out to each adder input.
    assign valid_out_1 = vld_p0;
    assign valid_out_2 = vld_p0;
    assign valid_out_3 = vld_p0;

endmodule

// File: tb/tb_split_3layers.sv
// Scoreboard bench for split_3layers with a word-grouping reference model.
module tb_split_3layers;
    localparam int D    = 4;
    localparam int DW   = 32;
    localparam int NPIX = D * D;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic          sof_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic [DW-1:0] pxl_out_1, pxl_out_2, pxl_out_3;
    logic          valid_out_1, valid_out_2, valid_out_3;
    logic          frame_done, err;

    split_3layers #(.D(D), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .sof_in(sof_in), .pxl_in(pxl_in),
        .pxl_out_1(pxl_out_1), .pxl_out_2(pxl_out_2), .pxl_out_3(pxl_out_3),
        .valid_out_1(valid_out_1), .valid_out_2(valid_out_2), .valid_out_3(valid_out_3),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic          fd;
    } trip_t;

    trip_t         exp_q[$];
    logic [DW-1:0] part[$];
    int            pix = 0;
    logic          exp_err = 1'b0;
    logic          mon_on = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect words since the last sof/triple; every third word completes a pixel.
    task automatic model_beat(input logic s, input logic [DW-1:0] w);
        trip_t t;
        if (s) begin
            if (part.size() != 0 || pix != 0) exp_err = 1'b1;
            part.delete();
            part.push_back(w);
            pix = 0;
        end else begin
            part.push_back(w);
            if (part.size() == 3) begin
                t.a  = part[0];
                t.b  = part[1];
                t.c  = part[2];
                t.fd = (pix == NPIX - 1);
                exp_q.push_back(t);
                pix = (pix + 1) % NPIX;
                part.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            sof_in   = 1'($urandom_range(0, 1));
            pxl_in   = $urandom;
            @(posedge clk);
        end
    endtask

    task automatic beat(input logic s, input logic [DW-1:0] w, input int gap);
        @(negedge clk);
        valid_in = 1'b1;
        sof_in   = s;
        pxl_in   = w;
        @(posedge clk);
        model_beat(s, w);
        idle(gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        @(posedge clk);
        part.delete();
        pix     = 0;
        exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out1", pxl_out_1, '0);
        check("rst_out2", pxl_out_2, '0);
        check("rst_out3", pxl_out_3, '0);
        check("rst_valid", {valid_out_1, valid_out_2, valid_out_3}, '0);
        check("rst_fd", frame_done, '0);
        check("rst_err", err, '0);
        reset = 1'b1;
    endtask

    // Monitor: every cycle compares err and, when valids are up, the next expected triple.
    initial begin
        trip_t t;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                check("err", err, exp_err);
                check("valid_eq", {valid_out_2, valid_out_3}, {valid_out_1, valid_out_1});
                if (valid_out_1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out: got %h/%h/%h expected no output at %0t",
                                 pxl_out_1, pxl_out_2, pxl_out_3, $time);
                    end else begin
                        t = exp_q.pop_front();
                        check("out1", pxl_out_1, t.a);
                        check("out2", pxl_out_2, t.b);
                        check("out3", pxl_out_3, t.c);
                        check("frame_done", frame_done, t.fd);
                    end
                end else begin
                    check("fd_idle", frame_done, '0);
                    check("missing_out", exp_q.size(), '0);
                    exp_q.delete();
                end
            end
        end
    end

    initial begin
        do_reset();
        mon_on = 1'b1;

        beat(1'b1, 32'h11, 0);
        beat(1'b0, 32'h22, 0);
        beat(1'b0, 32'h33, 0);
        beat(1'b0, 32'h44, 0);
        beat(1'b0, 32'h55, 0);
        beat(1'b0, 32'h66, 0);
        idle(3);

        // Rest of the frame with idle cycles between every word; triple 16 carries frame_done.
        for (int i = 0; i < 3 * (NPIX - 2); i++)
            beat(1'b0, $urandom, $urandom_range(1, 2));
        idle(2);

        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3 * NPIX; i++)
                beat(i == 0, $urandom, $urandom_range(0, 1));
        idle(2);
        check("err_clean", err, 1'b0);

        // Misaligned sof lands on a ch_cnt=2 cycle; partial A pixel must vanish.
        beat(1'b1, 32'hA1, 0);
        beat(1'b0, 32'hA2, 0);
        beat(1'b1, 32'h7001, 0);
        beat(1'b0, 32'h7002, 0);
        beat(1'b0, 32'h7003, 0);
        idle(2);
        check("err_set", err, 1'b1);
        for (int i = 0; i < 30; i++)
            beat(1'b0, $urandom, $urandom_range(0, 1));
        idle(2);
        check("err_sticky", err, 1'b1);

        beat(1'b1, 32'hC1, 0);
        beat(1'b0, 32'hC2, 0);
        do_reset();
        beat(1'b0, 32'h91, 0);
        beat(1'b0, 32'h92, 0);
        beat(1'b0, 32'h93, 0);
        idle(3);
        check("err_after_rst", err, 1'b0);

        for (int i = 0; i < 400; i++)
            beat(($urandom_range(0, 15) == 0), $urandom, $urandom_range(0, 1));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            idle(1);
        idle(2);
        check("drain", exp_q.size(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/split_3layers.md
Name: split_3layers

Overview:
- Channel deinterleaver at the input of the multi-layer accumulation path.
- Accepts one pixel stream carrying three channels interleaved per pixel (ch1, ch2, ch3, ch1, ...).
- Emits three aligned per-channel streams, with all valids asserted in the same cycle, ready to drive the 3-input layer adder chain.
- Counts pixels per D x D frame, flags the last pixel, and detects start-of-frame misalignment.

Parameters:
- D, 220, frame side length in pixels; a frame is D*D pixel triples.
- DATA_WIDTH, 32, width of each pixel word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- valid_in  input  1  pxl_in carries a valid channel word this cycle.
- sof_in  input  1  qualified by valid_in; this beat is ch1 of pixel 0 of a new frame.
- pxl_in  input  DATA_WIDTH  interleaved channel word.
- pxl_out_1  output  DATA_WIDTH  channel-1 word of the emitted pixel.
- pxl_out_2  output  DATA_WIDTH  channel-2 word of the emitted pixel.
- pxl_out_3  output  DATA_WIDTH  channel-3 word of the emitted pixel.
- valid_out_1  output  1  pxl_out_1 valid.
- valid_out_2  output  1  pxl_out_2 valid.
- valid_out_3  output  1  pxl_out_3 valid.
- frame_done  output  1  one-cycle pulse coincident with the valids of pixel D*D-1.
- err  output  1  sticky misalignment flag.

Behaviour:
- Reset (reset=0 at a clk edge):
  - ch_cnt=0, pix_cnt=0, hold registers=0.
  - All pxl_out_*=0, all valid_out_*=0, frame_done=0, err=0.
  - Reset mid-triple discards the partial pixel.
- ch_cnt (2 bits, values 0..2) advances only on valid_in=1. Cycles with valid_in=0 change no state; valid_out_* are 0 on those cycles.
- valid_in=1 with ch_cnt=0:
  - Capture pxl_in into hold1.
  - Set ch_cnt=1.
- valid_in=1 with ch_cnt=1:
  - Capture pxl_in into hold2.
  - Set ch_cnt=2.
- valid_in=1 with ch_cnt=2:
  - Next cycle: pxl_out_1=hold1, pxl_out_2=hold2, pxl_out_3=pxl_in.
  - Next cycle: valid_out_1/2/3=1 together for exactly one cycle.
  - Set ch_cnt=0.
- Latency: outputs appear 1 cycle after the ch3 beat is accepted.
- pxl_out_* hold their last value while valid_out_* are 0.
- The three valid_out_* are always identical; they are separate ports to match the adder inputs.
- pix_cnt (width clog2(D*D), 16 bits at D=220) increments on each emitted triple.
  - At D*D-1 it wraps to 0 on emission.
  - frame_done=1 in the same cycle as that emission's valids.
- sof_in with valid_in=1:
  - The beat is treated as ch1 regardless of ch_cnt: hold1=pxl_in, ch_cnt=1.
  - pix_cnt=0.
  - Any partial triple is discarded; no output is emitted for it.
  - If ch_cnt!=0 or pix_cnt!=0 at that beat, err sets to 1.
  - err stays set until reset.
  - sof_in with valid_in=0 is ignored.
- sof_in in a ch_cnt=2 cycle: the sof action wins; the pending triple is not emitted.
- Emission of a triple and sof on the next beat are independent. There is no stall; the block accepts one word per cycle, sustaining one pixel per 3 cycles.
- No back-pressure. Downstream must accept every valid.
- Arithmetic: none on data. Words pass bit-exact.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0; err=0; first valid_out only after 3 valid beats.
- sof at A1, then beats A1,A2,A3,B1,B2,B3 on consecutive cycles (A1=0x11, A2=0x22, A3=0x33) -> cycle after A3: outputs 0x11/0x22/0x33 with all valids=1. Cycle after B3: B triple with valids=1. Valids=0 on all other cycles. err=0.
- Beats separated by idle cycles (valid_in=0 between every word) -> identical output values; valids one cycle after each ch3 beat only.
- Full frame with D=4 override (16 triples, 48 beats) -> frame_done pulses exactly with triple 16. pix_cnt wraps. The next sof at a clean boundary leaves err=0.
- sof after beats A1,A2 only -> no A output emitted. err=1. Following X1,X2,X3 emit X correctly. err stays 1 until reset.
- Reset asserted after ch2 beat of a pixel, released, then 3 beats -> only the post-reset triple is emitted; err=0.
